// File: rtl/kronos_csr_arb.sv
// kronos_csr_arb: shares the machine CSR unit between the EX stage and the debug module,
// one transaction at a time, with a core starvation guard and a CSR-unit watchdog.
module kronos_csr_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_vld,
    input  logic [11:0] core_addr,
    input  logic [1:0]  core_op,
    input  logic [31:0] core_wdata,
    input  logic        core_wr,
    output logic        core_rdy,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_vld,
    input  logic [11:0] dbg_addr,
    input  logic [1:0]  dbg_op,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_wr,
    output logic        dbg_rdy,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    input  logic        trap_pending,
    output logic        csr_vld,
    output logic [11:0] csr_addr,
    output logic [1:0]  csr_op,
    output logic [31:0] csr_wdata,
    output logic        csr_wr,
    input  logic        csr_rdy,
    input  logic [31:0] csr_rdata,
    output logic        grant_dbg
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    state_t     state, state_nxt;
    logic       owner, grant, dbg_win, tmo_hit, done;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    always_comb begin
        dbg_win = dbg_vld && !(core_vld && starve_cnt == STARVE_MAX);
        grant   = state == IDLE && !trap_pending && (core_vld || dbg_vld);
        tmo_hit = TIMEOUT != 0 && tmo_cnt == TMO_LAST;
        done    = state == BUSY && (csr_rdy || tmo_hit);
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (grant ? BUSY : IDLE) :
                    state == BUSY ? (done ? RESP : BUSY) : IDLE;
    end
    always_comb begin
        csr_vld   = state == BUSY;
        core_rdy  = state == RESP && !owner;
        dbg_rdy   = state == RESP && owner;
        grant_dbg = state != IDLE && owner;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            csr_addr   <= '0;
            csr_op     <= '0;
            csr_wdata  <= '0;
            csr_wr     <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            if (grant) begin
                owner     <= dbg_win;
                csr_addr  <= dbg_win ? dbg_addr : core_addr;
                csr_op    <= dbg_win ? dbg_op : core_op;
                csr_wdata <= dbg_win ? dbg_wdata : core_wdata;
                csr_wr    <= dbg_win ? dbg_wr : core_wr;
            end
            // Starvation only accrues while the core is actually waiting in IDLE
            if (state == IDLE)
                starve_cnt <= !core_vld || (grant && !dbg_win) ? '0 :
                              grant && starve_cnt != STARVE_MAX ? starve_cnt + 4'd1 : starve_cnt;
            tmo_cnt <= state == BUSY ? tmo_cnt + 8'd1 : '0;
            if (done && owner) begin
                dbg_rdata <= csr_rdy ? csr_rdata : '0;
                dbg_err   <= !csr_rdy;
            end
            if (done && !owner) begin
                core_rdata <= csr_rdy ? csr_rdata : '0;
                core_err   <= !csr_rdy;
            end
        end
    end
endmodule

// File: tb/tb_kronos_csr_arb.sv
// tb_kronos_csr_arb: directed scenarios followed by random transactions, all checked
// against a transaction-level model of arbitration, starvation and the watchdog.
module tb_kronos_csr_arb;
    localparam int LIMIT = 4;
    localparam int TMO   = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic        core_vld = 0, core_wr = 0, dbg_vld = 0, dbg_wr = 0, trap_pending = 0, csr_rdy = 0;
    logic [11:0] core_addr = 0, dbg_addr = 0;
    logic [1:0]  core_op = 0, dbg_op = 0;
    logic [31:0] core_wdata = 0, dbg_wdata = 0, csr_rdata = 0;
    logic        core_rdy, core_err, dbg_rdy, dbg_err, csr_vld, csr_wr, grant_dbg;
    logic [31:0] core_rdata, dbg_rdata, csr_wdata;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    int checks = 0, errors = 0;
    int starve = 0;
    logic [31:0] core_last_rd = 0, dbg_last_rd = 0;
    logic        core_last_err = 0, dbg_last_err = 0;
    bit          got;
    int          nvld;
    bit          exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    kronos_csr_arb #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .core_vld(core_vld), .core_addr(core_addr), .core_op(core_op), .core_wdata(core_wdata),
        .core_wr(core_wr), .core_rdy(core_rdy), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_vld(dbg_vld), .dbg_addr(dbg_addr), .dbg_op(dbg_op), .dbg_wdata(dbg_wdata),
        .dbg_wr(dbg_wr), .dbg_rdy(dbg_rdy), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .trap_pending(trap_pending), .csr_vld(csr_vld), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_wr(csr_wr), .csr_rdy(csr_rdy), .csr_rdata(csr_rdata),
        .grant_dbg(grant_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"}, csr_vld, 0);
        chk({tag, "_rdy"}, {core_rdy, dbg_rdy}, 0);
        chk({tag, "_err"}, {core_err, dbg_err}, 0);
        chk({tag, "_crd"}, core_rdata, 0);
        chk({tag, "_drd"}, dbg_rdata, 0);
        chk({tag, "_pay"}, {csr_addr, csr_op, csr_wr}, 0);
        chk({tag, "_wd"}, csr_wdata, 0);
        chk({tag, "_gnt"}, grant_dbg, 0);
    endtask

    // One full transaction: optional trap hold-off, grant, BUSY for d+1 cycles (or until
    // the watchdog fires), the response pulse, and the return to IDLE.
    task automatic txn(input bit cv, input bit dv, input logic [11:0] ca, input logic [11:0] da,
                       input logic [1:0] co, input logic [1:0] dop, input logic [31:0] cwd,
                       input logic [31:0] dwd, input bit cwr, input bit dwr, input int trap_n,
                       input int d, input logic [31:0] rd, input bit trap_busy,
                       output bit got_dbg, output int vld_cycles);
        bit w, ok;
        int fin;
        logic [31:0] exp_wd;
        core_vld = cv; dbg_vld = dv; core_addr = ca; dbg_addr = da; core_op = co; dbg_op = dop;
        core_wdata = cwd; dbg_wdata = dwd; core_wr = cwr; dbg_wr = dwr;
        got_dbg = 0;
        vld_cycles = 0;
        trap_pending = trap_n > 0;
        for (int i = 0; i < trap_n; i++) begin
            if (!cv) starve = 0;
            tick();
            chk("trap_hold", csr_vld, 0);
        end
        trap_pending = 0;
        if (!cv && !dv) begin
            starve = 0;
            tick();
            chk("idle_novld", csr_vld, 0);
            return;
        end
        w = dv && !(cv && starve == LIMIT);
        starve = !cv ? 0 : w ? (starve < LIMIT ? starve + 1 : starve) : 0;
        exp_wd = w ? dwd : cwd;
        tick();
        got_dbg = grant_dbg;
        chk("grant_vld", csr_vld, 1);
        chk("grant_dbg", grant_dbg, w);
        chk("grant_addr", csr_addr, w ? da : ca);
        chk("grant_op", csr_op, w ? dop : co);
        chk("grant_wr", csr_wr, w ? dwr : cwr);
        core_vld = 0; dbg_vld = 0;
        core_addr = ~ca; dbg_addr = ~da; core_op = ~co; dbg_op = ~dop;
        core_wdata = ~cwd; dbg_wdata = ~dwd; core_wr = ~cwr; dbg_wr = ~dwr;
        trap_pending = trap_busy;
        fin = d < TMO ? d + 1 : TMO;
        for (int k = 0; k < fin; k++) begin
            if (csr_vld) vld_cycles++;
            chk("busy_wdata", csr_wdata, exp_wd);
            chk("busy_rdy", {core_rdy, dbg_rdy}, 0);
            csr_rdy = k == d;
            csr_rdata = k == d ? rd : $urandom;
            tick();
        end
        csr_rdy = 0;
        csr_rdata = $urandom;
        ok = d < TMO;
        if (w) begin
            dbg_last_rd = ok ? rd : 0;
            dbg_last_err = !ok;
        end else begin
            core_last_rd = ok ? rd : 0;
            core_last_err = !ok;
        end
        chk("resp_vld", csr_vld, 0);
        chk("resp_core_rdy", core_rdy, !w);
        chk("resp_dbg_rdy", dbg_rdy, w);
        chk("resp_gnt", grant_dbg, w);
        chk(w ? "resp_dbg_rdata" : "resp_core_rdata", w ? dbg_rdata : core_rdata,
            w ? dbg_last_rd : core_last_rd);
        chk(w ? "resp_dbg_err" : "resp_core_err", w ? dbg_err : core_err,
            w ? dbg_last_err : core_last_err);
        trap_pending = 0;
        tick();
        chk("idle_rdy", {core_rdy, dbg_rdy}, 0);
        chk("idle_gnt", grant_dbg, 0);
        chk("hold_core", {core_rdata, 31'b0, core_err}, {core_last_rd, 31'b0, core_last_err});
        chk("hold_dbg", {dbg_rdata, 31'b0, dbg_err}, {dbg_last_rd, 31'b0, dbg_last_err});
    endtask

    initial begin
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 0;
        tick();
        chk("post_reset_idle", csr_vld, 0);

        // Single core read of mstatus-like address; one csr_vld cycle
        txn(1, 0, 12'h300, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1888, 0, got, nvld);
        chk("single_vld_cycles", nvld, 1);
        chk("single_core_rdata", core_rdata, 32'h0000_1888);

        // Contention with both requesters valid at every arbitration
        for (int i = 0; i < 6; i++) begin
            txn(1, 1, 12'h340 + 12'(i), 12'h7b0 + 12'(i), 2'd1, 2'd2, $urandom, $urandom,
                1, 0, 0, 0, $urandom, 0, got, nvld);
            chk("contention_seq", got, exp_seq[i]);
        end

        // Watchdog: no csr_rdy, then csr_rdy on the last permitted BUSY cycle
        txn(0, 1, 0, 12'h7b1, 0, 2'd1, 0, 32'h1234_5678, 0, 1, 0, 999, 32'hdead_beef, 0, got, nvld);
        chk("timeout_vld_cycles", nvld, 16);
        chk("timeout_err", dbg_err, 1);
        chk("timeout_rdata", dbg_rdata, 0);
        txn(0, 1, 0, 12'h7b2, 0, 2'd1, 0, 32'h1, 0, 0, 0, 15, 32'hcafe_f00d, 0, got, nvld);
        chk("late_rdy_err", dbg_err, 0);
        chk("late_rdy_rdata", dbg_rdata, 32'hcafe_f00d);

        // Trap interlock before grant, then trap raised during BUSY
        txn(1, 0, 12'h305, 0, 2'd3, 0, 32'h5, 0, 1, 0, 5, 1, 32'h55, 0, got, nvld);
        txn(1, 0, 12'h341, 0, 2'd1, 0, 32'h9, 0, 1, 0, 0, 2, 32'h99, 1, got, nvld);

        // Payload stability for an all-ones write mask
        txn(1, 0, 12'h304, 0, 2'd2, 0, 32'hffff_ffff, 0, 1, 0, 0, 3, 32'h77, 0, got, nvld);

        // Core request withdrawn before it could be granted
        core_vld = 1;
        trap_pending = 1;
        tick();
        core_vld = 0;
        trap_pending = 0;
        starve = 0;
        tick();
        chk("cancel_vld0", csr_vld, 0);
        tick();
        chk("cancel_vld1", csr_vld, 0);

        // Reset while BUSY: no response, everything back to zero
        core_vld = 1; core_addr = 12'h342; core_wdata = 32'hffff_ffff; core_wr = 1;
        tick();
        chk("pre_rst_busy", csr_vld, 1);
        core_vld = 0;
        rst = 1;
        tick();
        chk_reset_outputs("mid_rst");
        rst = 0;
        starve = 0;
        core_last_rd = 0; core_last_err = 0; dbg_last_rd = 0; dbg_last_err = 0;
        tick();
        chk("post_rst_rdy", {core_rdy, dbg_rdy, csr_vld}, 0);
        txn(1, 0, 12'h300, 0, 2'd1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1800, 0, got, nvld);

        // Random transactions against the model
        for (int n = 0; n < 60; n++) begin
            txn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 12'($urandom),
                12'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom,
                1'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3) == 0 ? $urandom_range(0, TMO + 2) : $urandom_range(0, 3),
                $urandom, 1'($urandom), got, nvld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
